// File: rtl/r4_div_pkg.sv
// Shared definitions for the radix-4 SRT divider: digit encoding and OTFC state type.
package r4_div_pkg;

  localparam int DIG_W    = 5;
  localparam int DIG_NEG2 = 4;
  localparam int DIG_NEG1 = 3;
  localparam int DIG_ZERO = 2;
  localparam int DIG_POS1 = 1;
  localparam int DIG_POS2 = 0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ITER,
    S_DONE
  } otfc_state_t;

endpackage

// File: rtl/r4_otfc_step.sv
// One radix-4 on-the-fly conversion step: appends a signed digit to Q and QM = Q - 1.
module r4_otfc_step
  import r4_div_pkg::*;
#(
  parameter int W = 28
) (
  input  logic [W-1:0]     q,
  input  logic [W-1:0]     qm,
  input  logic [DIG_W-1:0] dig,
  output logic [W-1:0]     q_nxt,
  output logic [W-1:0]     qm_nxt,
  output logic             illegal
);

  always_comb begin
    illegal = !$onehot(dig);
    // Zero digit is the default, which also covers non-one-hot inputs.
    q_nxt   = {q[W-3:0], 2'd0};
    qm_nxt  = {qm[W-3:0], 2'd3};
    if (!illegal) begin
      if (dig[DIG_POS2]) begin
        q_nxt  = {q[W-3:0], 2'd2};
        qm_nxt = {q[W-3:0], 2'd1};
      end else if (dig[DIG_POS1]) begin
        q_nxt  = {q[W-3:0], 2'd1};
        qm_nxt = {q[W-3:0], 2'd0};
      end else if (dig[DIG_NEG1]) begin
        q_nxt  = {qm[W-3:0], 2'd3};
        qm_nxt = {qm[W-3:0], 2'd2};
      end else if (dig[DIG_NEG2]) begin
        q_nxt  = {qm[W-3:0], 2'd2};
        qm_nxt = {qm[W-3:0], 2'd1};
      end
    end
  end

endmodule

// File: rtl/r4_otfc.sv
// Radix-4 OTFC unit: sequences one digit per accepted beat and hands Q/QM downstream.
module r4_otfc
  import r4_div_pkg::*;
#(
  parameter int QUO_W = 28,
  parameter int ITER  = QUO_W / 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush_i,
  input  logic             start_valid_i,
  output logic             start_ready_o,
  input  logic             dig_valid_i,
  input  logic [DIG_W-1:0] dig_i,
  output logic             dig_ready_o,
  output logic             quo_valid_o,
  input  logic             quo_ready_i,
  output logic [QUO_W-1:0] quo_o,
  output logic [QUO_W-1:0] quo_m1_o,
  output logic             dig_err_o
);

  localparam int CNT_W = $clog2(ITER + 1);

  otfc_state_t      state, state_nxt;
  logic [QUO_W-1:0] q, qm, q_nxt, qm_nxt;
  logic [CNT_W-1:0] cnt;
  logic             err, illegal;
  logic             start_acc, dig_acc, res_acc, last_dig;

  assign start_ready_o = (state == S_IDLE);
  assign dig_ready_o   = (state == S_ITER);
  assign quo_valid_o   = (state == S_DONE);
  assign quo_o         = q;
  assign quo_m1_o      = qm;
  assign dig_err_o     = err;

  assign start_acc = start_valid_i & start_ready_o;
  assign dig_acc   = dig_valid_i & dig_ready_o;
  assign res_acc   = quo_valid_o & quo_ready_i;
  assign last_dig  = (cnt == CNT_W'(ITER - 1));

  r4_otfc_step #(.W(QUO_W)) u_step (
    .q       (q),
    .qm      (qm),
    .dig     (dig_i),
    .q_nxt   (q_nxt),
    .qm_nxt  (qm_nxt),
    .illegal (illegal)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start_acc) state_nxt = S_ITER;
      S_ITER:  if (dig_acc && last_dig) state_nxt = S_DONE;
      S_DONE:  if (res_acc) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    if (flush_i) state_nxt = S_IDLE;
  end

  // Handshakes are mutually exclusive by state, so one priority chain suffices.
  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      q   <= '0;
      qm  <= '0;
      cnt <= '0;
      err <= 1'b0;
    end else if (start_acc) begin
      q   <= '0;
      qm  <= '1;
      cnt <= '0;
      err <= 1'b0;
    end else if (dig_acc) begin
      q   <= q_nxt;
      qm  <= qm_nxt;
      cnt <= cnt + CNT_W'(1);
      err <= err | illegal;
    end
  end

endmodule
